ib_uart_fifo: RTL and testbench
===============================

Name: ib_uart_fifo

Overview:
- Byte buffer between the I/O-expander meter-to-host path and the UART transmitter.
- Absorbs bursts of meter output bytes while the UART is throttled by CTS, so the meter side is not stalled byte-by-byte at 7.3728 MHz.
- Upstream uses a level-valid / ack-pulse handshake with re-arm; downstream presents show-ahead data with a valid level and consumes on an ack edge.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  system clock, 7.3728 MHz.
- rst_n  in  1  synchronous reset, active low.
- in_data  in  8  byte from the meter side; stable while in_valid is high.
- in_valid  in  1  level, already synchronized to clk; held high until in_ack is seen.
- in_ack  out  1  one-cycle pulse: byte accepted.
- out_data  out  8  head-of-queue byte; valid whenever out_valid=1.
- out_valid  out  1  queue not empty; feeds UART data_valid.
- out_ack  in  1  consume strobe from the UART; rising edge pops one byte.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state registers update on posedge clk.
- Reset values: count=0, rd_ptr=0, wr_ptr=0, in_ack=0, out_valid=0, empty=1, full=0, out_ack_q=0, upstream FSM=IDLE. out_data is don't-care while out_valid=0. Memory contents are not reset.
- Upstream FSM, IDLE:
  - If in_valid=1 and full=0 at an edge: write in_data to mem[wr_ptr], increment wr_ptr, set in_ack=1 for exactly the next cycle, go to WAIT_LOW.
  - If in_valid=1 and full=1: stay in IDLE with in_ack=0. This is backpressure; no byte is ever dropped.
- Upstream FSM, WAIT_LOW:
  - in_ack=0. Stay until in_valid is sampled 0, then go to IDLE.
  - This guarantees one write per in_valid pulse, even if in_valid stays high for many cycles.
- full uses registered count. A pop in the same cycle does not permit a write that cycle; the write happens on the following edge.
- Downstream pop:
  - pop = out_ack & ~out_ack_q & ~empty. out_ack_q is out_ack registered.
  - On pop: increment rd_ptr. The new head appears on out_data the cycle after the pop edge.
  - out_ack rising while empty is ignored and has no side effects.
  - out_ack held high pops only once.
- Latency: a byte written at edge k makes out_valid=1 and out_data equal that byte from the cycle after edge k (the same cycle in_ack is high).
- count arithmetic:
  - write only: count+1.
  - pop only: count-1.
  - write and pop in the same edge: count unchanged, both pointers advance.
- Pointers are AW bits and wrap modulo DEPTH.
- Invariants: count never exceeds DEPTH and never underflows. full and empty are never both 1.
- out_data is mem[rd_ptr] read combinationally from registered storage. It must not glitch on a write to a different slot.
- Reset asserted mid-transfer:
  - Next edge returns everything to reset values and discards the queue.
  - If in_valid is still high after reset, the FSM starts in IDLE and accepts that byte again. The upstream producer is reset alongside this block.

Test Plan:
1. Reset, then in_valid=1 with in_data=0x5A. Required: in_ack pulses for 1 cycle; out_valid=1, out_data=0x5A, count=1. Then out_ack rises. Required: count=0, out_valid=0, empty=1.
2. Hold in_valid=1 for 10 cycles with data 0x33. Required: exactly one in_ack, count=1. Drop in_valid, then present 0x44. Required: count=2, and the pop order is 0x33 then 0x44.
3. Fill with 0x00..0x0F. Required: full=1, count=16. Present 0x10. Required: no in_ack while full. Pop once. Required: 0x10 is accepted one edge after full deasserts, count returns to 16.
4. Stream 0x00..0x2F with interleaved pops so the pointers wrap 3 times. Required: output sequence identical to input; count never exceeds 16.
5. Write and pop on the same edge at count=5. Required: count stays 5. Also hold out_ack high for 4 cycles. Required: only one pop.
6. At count=7, assert rst_n=0 for 1 cycle. Required: count=0, empty=1, in_ack=0, out_valid=0. Pulse out_ack while empty. Required: no change.

Source files
------------

// File: rtl/ib_uart_fifo.sv
// ib_uart_fifo: byte FIFO between the meter-side level/ack producer and the CTS-throttled UART.
// Upstream accepts once per in_valid assertion; downstream pops on each out_ack rising edge.
module ib_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ack,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ack,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    typedef enum logic {IDLE, WAIT_LOW} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          out_ack_q;
    logic          wr;
    logic          pop;

    assign full      = count == (AW+1)'(DEPTH);
    assign empty     = count == '0;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];
    // full is taken from registered count, so a same-edge pop never frees room for a write
    assign wr  = state == IDLE && in_valid && !full;
    assign pop = out_ack & ~out_ack_q & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ack    <= 1'b0;
            out_ack_q <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= wr ? WAIT_LOW : (state == WAIT_LOW && !in_valid) ? IDLE : state;
            in_ack    <= wr;
            out_ack_q <= out_ack;
            rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr    <= wr ? wr_ptr + AW'(1) : wr_ptr;
            count     <= count + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_ib_uart_fifo.sv
// tb_ib_uart_fifo: randomized/directed bench with a queue-based reference model and pop-order scoreboard.
module tb_ib_uart_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ack = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    ib_uart_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // reference model: contents as a queue, plus one-write-per-pulse and edge-pop rules
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    bit         m_wait = 0;
    bit         m_ack_prev = 0;
    bit         m_in_ack = 0;
    int         max_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit w, p;
        if (!rst_n) begin
            mq.delete();
            m_wait = 0;
            m_ack_prev = 0;
            m_in_ack = 0;
        end else begin
            w = in_valid && !m_wait && mq.size() < DEPTH;
            p = out_ack && !m_ack_prev && mq.size() > 0;
            if (p) void'(mq.pop_front());
            if (w) mq.push_back(in_data);
            m_in_ack = w;
            m_wait = w || (m_wait && in_valid);
            m_ack_prev = out_ack;
        end
    end

    // monitor: compare every cycle away from the active edge; score each pop against issue order
    always @(negedge clk) begin
        chk("count", int'(count), mq.size());
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("out_valid", int'(out_valid), int'(mq.size() != 0));
        chk("in_ack", int'(in_ack), int'(m_in_ack));
        if (mq.size() > 0) chk("out_data", int'(out_data), int'(mq[0]));
        if (int'(count) > max_count) max_count = int'(count);
        if (rst_n && out_ack && !m_ack_prev && out_valid) begin
            if (sent_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_order", int'(out_data), int'(sent_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        sent_q.push_back(b);
        do begin
            step();
            n++;
        end while (!in_ack && n < 200);
        if (!in_ack) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        step();
    endtask

    task automatic pop_one();
        int n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        if (!out_valid) chk("pop_timeout", 0, 1);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        step();
    endtask

    initial begin
        int acks;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);

        // 1: single byte in and out
        send(8'h5A);
        chk("t1_count", int'(count), 1);
        pop_one();
        chk("t1_empty", int'(empty), 1);

        // 2: long in_valid gives one write
        in_data = 8'h33;
        in_valid = 1'b1;
        sent_q.push_back(8'h33);
        acks = 0;
        repeat (10) begin
            step();
            acks += int'(in_ack);
        end
        chk("t2_acks", acks, 1);
        chk("t2_count", int'(count), 1);
        in_valid = 1'b0;
        step();
        send(8'h44);
        chk("t2_count2", int'(count), 2);
        pop_one();
        pop_one();

        // 3: fill, backpressure, then accept one edge after full drops
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("t3_full", int'(full), 1);
        in_data = 8'h10;
        in_valid = 1'b1;
        sent_q.push_back(8'h10);
        repeat (5) begin
            step();
            chk("t3_no_ack", int'(in_ack), 0);
        end
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("t3_ack_late", int'(in_ack), 0);
        chk("t3_not_full", int'(full), 0);
        step();
        chk("t3_ack", int'(in_ack), 1);
        chk("t3_count", int'(count), 16);
        in_valid = 1'b0;
        step();
        repeat (16) pop_one();

        // 4: random interleaved stream wrapping the pointers
        max_count = 0;
        fork
            for (int i = 0; i < 48; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send(8'(i));
            end
            for (int i = 0; i < 48; i++) begin
                repeat ($urandom_range(0, 6)) step();
                pop_one();
            end
        join
        chk("t4_max", int'(max_count <= 16), 1);
        chk("t4_drained", sent_q.size(), 0);

        // 5: simultaneous write/pop, and held out_ack
        for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
        in_data = 8'hC5;
        in_valid = 1'b1;
        out_ack = 1'b1;
        sent_q.push_back(8'hC5);
        step();
        chk("t5_ack", int'(in_ack), 1);
        chk("t5_count", int'(count), 5);
        in_valid = 1'b0;
        repeat (3) step();
        chk("t5_held", int'(count), 5);
        out_ack = 1'b0;
        step();

        // 6: reset mid-queue, then empty pop is ignored
        send(8'h71);
        send(8'h72);
        chk("t6_count7", int'(count), 7);
        rst_n = 1'b0;
        sent_q.delete();
        step();
        rst_n = 1'b1;
        chk("t6_count", int'(count), 0);
        chk("t6_empty", int'(empty), 1);
        chk("t6_in_ack", int'(in_ack), 0);
        chk("t6_valid", int'(out_valid), 0);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        step();
        chk("t6_ign", int'(count), 0);
        send(8'hE7);
        chk("t6_data", int'(out_data), 8'hE7);
        pop_one();
        chk("t6_final", int'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
